bus_arb_18: RTL and testbench

BUS_ARB_18 -- requirements
Module: bus_arb_18

---
 rtl/bus_arb_18.sv | 132 +++++++++++++
 tb/tb_bus_arb_18.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arb_18.sv
// Six-requester round-robin arbiter for an 18-bit source mux, with a one-cycle
// turnaround between owners and preemption after MAX_HOLD cycles under contention.
module bus_arb_18 #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] req,
    output logic [5:0] gnt,
    output logic [2:0] sel,
    output logic       bus_valid,
    output logic       preempt
);

    typedef enum logic [1:0] {
        IDLE,
        OWN,
        TURN
    } state_t;

    localparam logic [7:0] HOLD_MAX  = 8'(MAX_HOLD);
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state, state_nx;
    logic [2:0] owner, owner_nx;
    logic [2:0] last_owner, last_nx;
    logic [7:0] hold_cnt, hold_nx;
    logic       preempt_nx;
    logic [5:0] gnt_nx;
    logic [2:0] sel_nx;
    logic       valid_nx;
    logic [2:0] winner;
    logic       any_req;
    logic       others;

    assign any_req = |req;
    assign others  = |(req & ~(6'b000001 << owner));

    // Round-robin search beginning just after the previous owner, wrapping 5 -> 0.
    always_comb begin
        logic       found;
        logic [3:0] idx;
        winner = 3'd0;
        found  = 1'b0;
        idx    = 4'd0;
        for (int i = 1; i <= 6; i++) begin
            idx = {1'b0, last_owner} + 4'(i);
            if (idx >= 4'd6)
                idx = idx - 4'd6;
            if (!found && req[idx[2:0]]) begin
                winner = idx[2:0];
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 3'd0;
            last_owner <= 3'd5;
            hold_cnt   <= 8'd0;
            gnt        <= 6'b000000;
            sel        <= 3'b111;
            bus_valid  <= 1'b0;
            preempt    <= 1'b0;
        end else begin
            state      <= state_nx;
            owner      <= owner_nx;
            last_owner <= last_nx;
            hold_cnt   <= hold_nx;
            gnt        <= gnt_nx;
            sel        <= sel_nx;
            bus_valid  <= valid_nx;
            preempt    <= preempt_nx;
        end
    end

    // A release by the owner takes precedence over expiry, so no preempt then.
    always_comb begin
        state_nx   = state;
        owner_nx   = owner;
        last_nx    = last_owner;
        hold_nx    = hold_cnt;
        preempt_nx = 1'b0;
        case (state)
            IDLE, TURN: begin
                if (any_req) begin
                    state_nx = OWN;
                    owner_nx = winner;
                    hold_nx  = 8'd0;
                end else begin
                    state_nx = IDLE;
                end
            end
            OWN: begin
                if (!req[owner]) begin
                    state_nx = TURN;
                    last_nx  = owner;
                end else if (hold_cnt >= HOLD_LAST && others) begin
                    state_nx   = TURN;
                    last_nx    = owner;
                    preempt_nx = 1'b1;
                end else if (hold_cnt < HOLD_MAX) begin
                    hold_nx = hold_cnt + 8'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they leave the flops glitch-free.
    always_comb begin
        gnt_nx   = 6'b000000;
        sel_nx   = 3'b111;
        valid_nx = 1'b0;
        if (state_nx == OWN) begin
            gnt_nx   = 6'b000001 << owner_nx;
            valid_nx = 1'b1;
            case (owner_nx)
                3'd0:    sel_nx = 3'b000;
                3'd1:    sel_nx = 3'b001;
                3'd2:    sel_nx = 3'b010;
                3'd3:    sel_nx = 3'b100;
                3'd4:    sel_nx = 3'b101;
                3'd5:    sel_nx = 3'b110;
                default: sel_nx = 3'b111;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arb_18.sv
// Bench for bus_arb_18: two instances (MAX_HOLD 8 and 4) driven by the same
// request vector, each checked every cycle against an owner/count/last model.
module tb_bus_arb_18;

    logic       clk;
    logic       rst;
    logic [5:0] req;
    logic [5:0] gntA   [2];
    logic [2:0] selA   [2];
    logic       validA [2];
    logic       preA   [2];

    int checks   = 0;
    int failures = 0;

    int mOwner [2];
    int mCnt   [2];
    int mLast  [2];
    int mPre   [2];
    int holdLimit [2] = '{8, 4};
    int selMap    [6] = '{0, 1, 2, 4, 5, 6};

    bus_arb_18 #(.MAX_HOLD(8)) dut8 (
        .clk(clk), .rst(rst), .req(req),
        .gnt(gntA[0]), .sel(selA[0]), .bus_valid(validA[0]), .preempt(preA[0])
    );

    bus_arb_18 #(.MAX_HOLD(4)) dut4 (
        .clk(clk), .rst(rst), .req(req),
        .gnt(gntA[1]), .sel(selA[1]), .bus_valid(validA[1]), .preempt(preA[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [5:0] value);
        req = value;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic doReset();
        tick();
        #1 rst = 1'b1;
        tick();
        #1 rst = 1'b0;
        tick();
    endtask

    // Model: an owner index (-1 when nobody owns), cycles held, and last owner.
    task automatic modelStep(input int i);
        int o;
        int c;
        logic [5:0] rest;
        if (rst) begin
            mOwner[i] = -1;
            mCnt[i]   = 0;
            mLast[i]  = 5;
            mPre[i]   = 0;
        end else begin
            mPre[i] = 0;
            if (mOwner[i] >= 0) begin
                o    = mOwner[i];
                rest = req & ~(6'(1) << o);
                if (!req[o]) begin
                    mLast[i]  = o;
                    mOwner[i] = -1;
                end else if (mCnt[i] + 1 >= holdLimit[i] && rest != 6'd0) begin
                    mLast[i]  = o;
                    mOwner[i] = -1;
                    mPre[i]   = 1;
                end else if (mCnt[i] < holdLimit[i]) begin
                    mCnt[i] = mCnt[i] + 1;
                end
            end else begin
                for (int k = 1; k <= 6; k++) begin
                    c = (mLast[i] + k) % 6;
                    if (mOwner[i] < 0 && req[c]) begin
                        mOwner[i] = c;
                        mCnt[i]   = 0;
                    end
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            mOwner[i] = -1;
            mCnt[i]   = 0;
            mLast[i]  = 5;
            mPre[i]   = 0;
        end
        forever begin
            @(posedge clk or posedge rst);
            for (int i = 0; i < 2; i++)
                modelStep(i);
        end
    end

    initial begin
        logic [5:0] expG;
        logic [2:0] expS;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                expG = (mOwner[i] < 0) ? 6'd0 : 6'(1) << mOwner[i];
                expS = (mOwner[i] < 0) ? 3'b111 : 3'(selMap[mOwner[i]]);
                checkOutput($sformatf("model%0d_gnt", i), 8'(gntA[i]), 8'(expG));
                checkOutput($sformatf("model%0d_sel", i), 8'(selA[i]), 8'(expS));
                checkOutput($sformatf("model%0d_valid", i), 8'(validA[i]), 8'(mOwner[i] >= 0));
                checkOutput($sformatf("model%0d_preempt", i), 8'(preA[i]), 8'(mPre[i]));
                checkOutput($sformatf("model%0d_onehot", i), 8'($onehot0(gntA[i])), 8'd1);
            end
        end
    end

    initial begin
        logic [5:0] pat;
        int         e;
        rst = 1'b1;
        req = 6'b000000;
        tick();
        tick();
        checkOutput("reset_gnt", 8'(gntA[0]), 8'h00);
        checkOutput("reset_sel", 8'(selA[0]), 8'h07);
        checkOutput("reset_valid", 8'(validA[0]), 8'h00);
        checkOutput("reset_preempt", 8'(preA[1]), 8'h00);
        #1 rst = 1'b0;
        tick();

        // Single request, release, turnaround, idle.
        applyStimulus(6'b000001);
        tick();
        checkOutput("a_gnt", 8'(gntA[0]), 8'h01);
        checkOutput("a_sel", 8'(selA[0]), 8'h00);
        checkOutput("a_valid", 8'(validA[0]), 8'h01);
        applyStimulus(6'b000000);
        tick();
        checkOutput("a_turn_gnt", 8'(gntA[0]), 8'h00);
        checkOutput("a_turn_sel", 8'(selA[0]), 8'h07);
        checkOutput("a_turn_valid", 8'(validA[0]), 8'h00);
        tick();
        checkOutput("a_idle_sel", 8'(selA[0]), 8'h07);

        // Requesters 2 and 5 alternate with a dead cycle in between.
        applyStimulus(6'b100100);
        for (int g = 0; g < 4; g++) begin
            e = (g % 2 == 0) ? 2 : 5;
            tick();
            checkOutput($sformatf("b_gnt%0d", g), 8'(gntA[0]), 8'(6'(1) << e));
            checkOutput($sformatf("b_sel%0d", g), 8'(selA[0]), (e == 2) ? 8'h02 : 8'h06);
            tick();
            tick();
            applyStimulus(6'b100100 & ~(6'(1) << e));
            tick();
            checkOutput($sformatf("b_dead%0d", g), 8'(gntA[0]), 8'h00);
            applyStimulus((g == 3) ? 6'b000000 : 6'b100100);
        end
        tick();

        // Preemption of requester 1 by requester 3 with MAX_HOLD = 4.
        doReset();
        applyStimulus(6'b000010);
        tick();
        checkOutput("c_gnt_first", 8'(gntA[1]), 8'h02);
        applyStimulus(6'b001010);
        tick();
        tick();
        tick();
        checkOutput("c_gnt_fourth", 8'(gntA[1]), 8'h02);
        checkOutput("c_no_early_preempt", 8'(preA[1]), 8'h00);
        tick();
        checkOutput("c_turn_gnt", 8'(gntA[1]), 8'h00);
        checkOutput("c_preempt", 8'(preA[1]), 8'h01);
        tick();
        checkOutput("c_new_gnt", 8'(gntA[1]), 8'h08);
        checkOutput("c_new_sel", 8'(selA[1]), 8'h04);
        checkOutput("c_preempt_clear", 8'(preA[1]), 8'h00);
        checkOutput("c_hold8_still", 8'(gntA[0]), 8'h02);
        applyStimulus(6'b000000);
        repeat (3) tick();

        // Lone requester 4 keeps the bus; a late competitor triggers expiry.
        applyStimulus(6'b010000);
        for (int c = 0; c < 20; c++) begin
            tick();
            checkOutput($sformatf("d_gnt%0d", c), 8'(gntA[0]), 8'h10);
            checkOutput($sformatf("d_pre%0d", c), 8'(preA[0]), 8'h00);
        end
        applyStimulus(6'b010001);
        tick();
        checkOutput("d_late_preempt8", 8'(preA[0]), 8'h01);
        checkOutput("d_late_preempt4", 8'(preA[1]), 8'h01);
        tick();
        checkOutput("d_next_owner", 8'(gntA[0]), 8'h01);
        applyStimulus(6'b000000);
        repeat (3) tick();

        // All requesters, two-cycle tenures, order must wrap back to 0.
        doReset();
        applyStimulus(6'b111111);
        for (int k = 0; k < 7; k++) begin
            e = k % 6;
            tick();
            checkOutput($sformatf("e_order%0d", k), 8'(gntA[0]), 8'(6'(1) << e));
            tick();
            pat = 6'b111111 & ~(6'(1) << e);
            applyStimulus(pat);
            tick();
            checkOutput($sformatf("e_dead%0d", k), 8'(gntA[0]), 8'h00);
            applyStimulus((k == 6) ? 6'b000000 : 6'b111111);
        end
        tick();

        // Brief reset while requester 2 owns the bus.
        doReset();
        applyStimulus(6'b000100);
        tick();
        checkOutput("f_gnt2", 8'(gntA[0]), 8'h04);
        applyStimulus(6'b000110);
        tick();
        checkOutput("f_nonowner_noeffect", 8'(gntA[0]), 8'h04);
        #1 rst = 1'b1;
        #1;
        checkOutput("f_async_gnt8", 8'(gntA[0]), 8'h00);
        checkOutput("f_async_gnt4", 8'(gntA[1]), 8'h00);
        checkOutput("f_async_sel", 8'(selA[0]), 8'h07);
        #2 rst = 1'b0;
        tick();
        checkOutput("f_regrant", 8'(gntA[0]), 8'h02);
        checkOutput("f_regrant_sel", 8'(selA[0]), 8'h01);
        applyStimulus(6'b000000);
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
